// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default sizes for the debouncer
package debounce_pkg;
  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} dbnc_state_t;
  localparam int DBNC_CNT_W = 20;
  localparam int DBNC_SYNC_STAGES = 2;
endpackage

// File: rtl/debounce_multi_if.sv
// debounce_multi_if: control inputs and debounced outputs of the multi-channel debouncer
interface debounce_multi_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 20
);
  logic tick;
  logic [CNT_W-1:0] thresh;
  logic [CHANNELS-1:0] switch;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic [CHANNELS-1:0] long_pulse;
  modport master (output tick, thresh, switch, input level, rise_pulse, fall_pulse, long_pulse);
  modport slave (input tick, thresh, switch, output level, rise_pulse, fall_pulse, long_pulse);
endinterface

// File: rtl/debounce_chan.sv
// debounce_chan: per-channel debounce FSM with registered level, edge and long-press pulses
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int CNT_W = DBNC_CNT_W,
  parameter int unsigned LONG_CNT = 20'hFFFFF
) (
  input  logic clk,
  input  logic nReset,
  input  logic s_i,
  input  logic tick_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o
);
  localparam logic [CNT_W-1:0] LONG = CNT_W'(LONG_CNT);
  localparam logic [CNT_W-1:0] DEC = CNT_W'(1);
  dbnc_state_t state_q;
  logic [CNT_W-1:0] cnt_q, hold_q;
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ZERO;
      cnt_q <= '0;
      hold_q <= '0;
      level_o <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      long_o <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      // a zero hold time fires right after the rise, since hold never sees 1 -> 0
      long_o <= (LONG == '0) && rise_o;
      case (state_q)
        ZERO:
          if (s_i) begin
            state_q <= WAIT1;
            cnt_q <= thresh_i;
          end
        WAIT1:
          if (!s_i) state_q <= ZERO;
          else if (tick_i && cnt_q == '0) begin
            state_q <= ONE;
            hold_q <= LONG;
            level_o <= 1'b1;
            rise_o <= 1'b1;
          end else if (tick_i) cnt_q <= cnt_q - DEC;
        ONE:
          if (!s_i) begin
            state_q <= WAIT0;
            cnt_q <= thresh_i;
          end else if (tick_i && hold_q != '0) begin
            hold_q <= hold_q - DEC;
            long_o <= hold_q == DEC;
          end
        WAIT0:
          if (s_i) state_q <= ONE;
          else if (tick_i && cnt_q == '0) begin
            state_q <= ZERO;
            level_o <= 1'b0;
            fall_o <= 1'b1;
          end else if (tick_i) cnt_q <= cnt_q - DEC;
        default: state_q <= ZERO;
      endcase
    end
  end
endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: synchronises raw switch inputs and debounces each channel independently
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W = DBNC_CNT_W,
  parameter int SYNC_STAGES = DBNC_SYNC_STAGES,
  parameter int unsigned LONG_CNT = 20'hFFFFF
) (
  input logic clk,
  input logic nReset,
  debounce_multi_if.slave bus
);
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] level_w, rise_w, fall_w, long_w;
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= bus.switch;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    debounce_chan #(.CNT_W(CNT_W), .LONG_CNT(LONG_CNT)) u_chan (
      .clk(clk),
      .nReset(nReset),
      .s_i(sync_q[SYNC_STAGES-1][c]),
      .tick_i(bus.tick),
      .thresh_i(bus.thresh),
      .level_o(level_w[c]),
      .rise_o(rise_w[c]),
      .fall_o(fall_w[c]),
      .long_o(long_w[c])
    );
  end
  assign bus.level = level_w;
  assign bus.rise_pulse = rise_w;
  assign bus.fall_pulse = fall_w;
  assign bus.long_pulse = long_w;
endmodule
